// File: rtl/spi_slave_param.sv
// Clocked SPI slave: 2 command bits + DATA_W payload bits per frame, with address/data read-back.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output (truncated frame / aborted read-back).
module spi_slave_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int unsigned         CntW   = $clog2(DATA_W + 2);
  localparam logic [CntW-1:0]     RxLast = CntW'(DATA_W + 1);
  localparam logic [CntW-1:0]     TxLast = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StChkCmd, StWrite, StReadAdd, StReadData} state_e;
  // Sub-phase inside WRITE/READ_ADD/READ_DATA.
  typedef enum logic [1:0] {PhShift, PhTxWait, PhTxDrive, PhHold} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W:0]     rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W+1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_done_q, rd_addr_done_d;
  logic                armed_q, armed_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                frame_err_q, frame_err_d;
`endif

  logic [DATA_W+1:0]   word_raw;
  logic [DATA_W-1:0]   payload;

  // Word as it stands once the current MOSI bit is included, payload put back in natural order.
  always_comb begin
    word_raw = {rx_sr_q, MOSI};
    payload  = word_raw[DATA_W-1:0];
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < DATA_W; i++) begin
        payload[i] = word_raw[DATA_W-1-i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      phase_q        <= PhShift;
      cnt_q          <= '0;
      rx_sr_q        <= '0;
      tx_sr_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
      armed_q        <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
      armed_q        <= armed_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    // After reset a frame may only start once SS_n has been seen high.
    armed_d        = armed_q | SS_n;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        phase_d = PhShift;
        if (!SS_n && armed_q) begin
          state_d = StChkCmd;
          rx_sr_d = '0;
        end
      end
      StChkCmd: begin
        if (SS_n) begin
          state_d = StIdle;
        end else begin
          rx_sr_d = {rx_sr_q[DATA_W-1:0], MOSI};
          cnt_d   = CntW'(1);
          if (!MOSI)               state_d = StWrite;
          else if (rd_addr_done_q) state_d = StReadData;
          else                     state_d = StReadAdd;
        end
      end
      default: begin
        case (phase_q)
          PhShift: begin
            rx_sr_d = {rx_sr_q[DATA_W-1:0], MOSI};
            if (cnt_q == RxLast) begin
              rx_valid_d = 1'b1;
              rx_data_d  = {word_raw[DATA_W+1:DATA_W], payload};
              cnt_d      = '0;
              if (state_q == StReadAdd) rd_addr_done_d = 1'b1;
              phase_d = (state_q == StReadData) ? PhTxWait : PhHold;
            end else begin
              cnt_d = cnt_q + 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
              frame_err_d = SS_n;
`endif
            end
          end
          PhTxWait: begin
            if (tx_valid) begin
              tx_sr_d = tx_data;
              phase_d = PhTxDrive;
              cnt_d   = '0;
            end
          end
          PhTxDrive: begin
            tx_sr_d = (LSB_FIRST != 0) ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            if (cnt_q == TxLast) begin
              rd_addr_done_d = 1'b0;
              phase_d        = PhHold;
              cnt_d          = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_d = SS_n;
`endif
          end
          default: ;
        endcase
        // Deselect wins over everything except capturing the final bit above.
        if (SS_n) begin
          state_d = StIdle;
          phase_d = PhShift;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    MISO = 1'b0;
    if (phase_q == PhTxDrive) begin
      MISO = (LSB_FIRST != 0) ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboarded bench for spi_slave_param: an MSB-first and an LSB-first instance share one stimulus.
// Expected words and MISO bits are queued by the stimulus and consumed by a negedge monitor.
module tb_spi_slave_param;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ss_n;
  logic             mosi;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic [1:0]       miso_w;
  logic [1:0]       rx_valid_w;
  logic [1:0][9:0]  rx_data_w;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic [1:0]       frame_err_w;
  int               fe_seen = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    int         c;
  } rx_exp_t;

  rx_exp_t    rxq[$];
  logic [1:0] misoq[$];
  rx_exp_t    mon_e;
  logic [1:0] mon_miso;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(0)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso_w[0]),
    .rx_data  (rx_data_w[0]),
    .rx_valid (rx_valid_w[0]),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err_w[0])
`endif
  );

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso_w[1]),
    .rx_data  (rx_data_w[1]),
    .rx_valid (rx_valid_w[1]),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err_w[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rd_done();
    return {dut_b.rd_addr_done_q, dut_a.rd_addr_done_q};
  endfunction

  // Monitor: every rx_valid must match the oldest queued word and its cycle; MISO every cycle.
  always @(negedge clk) begin
    if (rx_valid_w != 2'b00) begin
      if (rxq.size() == 0) begin
        check("unexpected_rx_valid", 32'(rx_valid_w), 32'd0);
      end else begin
        mon_e = rxq.pop_front();
        check("rx_valid_both", 32'(rx_valid_w), 32'd3);
        check("rx_data_msb_first", 32'(rx_data_w[0]), 32'(mon_e.a));
        check("rx_data_lsb_first", 32'(rx_data_w[1]), 32'(mon_e.b));
        check("rx_valid_cycle", cyc, mon_e.c);
      end
    end
    mon_miso = (misoq.size() != 0) ? misoq.pop_front() : 2'b00;
    check("miso", 32'(miso_w), 32'(mon_miso));
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err_w[0]) fe_seen++;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_valid"}, 32'(rx_valid_w), 32'd0);
    check({tag, "_rx_data_a"}, 32'(rx_data_w[0]), 32'd0);
    check({tag, "_rx_data_b"}, 32'(rx_data_w[1]), 32'd0);
    check({tag, "_miso"}, 32'(miso_w), 32'd0);
    check({tag, "_rd_addr_done"}, 32'(rd_done()), 32'd0);
  endtask

  // seq holds the payload in wire order (seq[7] sent first); exp_* are the hand-computed words.
  task automatic frame(input logic [1:0] cmd, input logic [7:0] seq, input logic [9:0] exp_a,
                       input logic [9:0] exp_b, input bit ss_last_high);
    ss_n = 1'b0;
    tick();
    mosi = cmd[1];
    tick();
    mosi = cmd[0];
    tick();
    for (int i = 7; i >= 0; i--) begin
      mosi = seq[i];
      if (i == 0 && ss_last_high) ss_n = 1'b1;
      tick();
    end
    rxq.push_back('{exp_a, exp_b, cyc});
  endtask

  // wire_a/wire_b: expected MISO bits in time order, first bit in [7].
  task automatic readback(input logic [7:0] d, input logic [7:0] wire_a, input logic [7:0] wire_b,
                          input int nbits);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < nbits; i++) misoq.push_back({wire_b[7-i], wire_a[7-i]});
    for (int i = 0; i < nbits; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    #12;
    check_reset_state("por");
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();

    // First 1,1 frame after reset takes the address path and drives nothing.
    frame(2'b11, 8'h00, 10'h300, 10'h300, 1'b0);
    tick();
    check("rd_done_after_first_11", 32'(rd_done()), 32'd3);
    tx_data = 8'h96; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    tick(); tick();
    ss_n = 1'b1; tick();
    tx_valid = 1'b1; tick(); tx_valid = 1'b0; tick();   // ignored while idle

    rst_n = 1'b0;
    #2;
    check_reset_state("rst2");
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();

    // Write 0xA5; extra clocks after the word are ignored.
    frame(2'b00, 8'hA5, 10'h0A5, 10'h0A5, 1'b0);
    mosi = 1'b1;
    repeat (4) tick();
    ss_n = 1'b1; tick();

    // Read address then read data with read-back of 0x96.
    frame(2'b10, 8'h3C, 10'h23C, 10'h23C, 1'b0);
    tick();
    check("rd_done_after_read_add", 32'(rd_done()), 32'd3);
    ss_n = 1'b1; tick();
    frame(2'b11, 8'h00, 10'h300, 10'h300, 1'b0);
    tick(); tick();
    readback(8'h96, 8'h96, 8'h69, 8);
    check("rd_done_after_readback", 32'(rd_done()), 32'd0);
    ss_n = 1'b1; tick();

    // Abort after 5 bits, then a clean write frame.
    ss_n = 1'b0; tick();
    mosi = 1'b0; tick();
    mosi = 1'b1; tick();
    mosi = 1'b1; tick();
    mosi = 1'b0; tick();
    mosi = 1'b1; tick();
    ss_n = 1'b1; tick();
    frame(2'b01, 8'h12, 10'h112, 10'h148, 1'b0);
    ss_n = 1'b1; tick();

    // Deselect on the same edge as the final bit still delivers the word.
    frame(2'b00, 8'h0F, 10'h00F, 10'h0F0, 1'b1);
    tick(); tick();

    // Reset during the 4th read-back bit.
    frame(2'b10, 8'h55, 10'h255, 10'h2AA, 1'b0);
    ss_n = 1'b1; tick();
    frame(2'b11, 8'h00, 10'h300, 10'h300, 1'b0);
    tick();
    readback(8'h96, 8'h96, 8'h69, 3);
    check("miso_4th_bit_before_reset", 32'(miso_w), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_miso");

    // SS_n still low across reset release: no frame until SS_n goes high and low again.
    @(negedge clk) rst_n = 1'b1;
    repeat (12) begin
      mosi = ~mosi;
      tick();
    end
    check("rd_done_no_restart", 32'(rd_done()), 32'd0);
    ss_n = 1'b1; tick();
    frame(2'b01, 8'hE1, 10'h1E1, 10'h187, 1'b0);
    ss_n = 1'b1; tick(); tick(); tick();

    check("rx_queue_drained", rxq.size(), 32'd0);
    check("miso_queue_drained", misoq.size(), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("frame_err_pulses", fe_seen, 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
- REQ-001: Parameter DATA_W, default 8, payload/address width in bits; legal range 4..32.
- REQ-002: Parameter LSB_FIRST, default 0. 0 = payload MSB first on MOSI/MISO; 1 = payload LSB first. The 2 command bits are always MSB first.
- REQ-003: clk  input  1  system clock; doubles as SPI bit clock, all sampling on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: SS_n  input  1  slave select, active-low; frame delimiter.
- REQ-006: MOSI  input  1  serial data in.
- REQ-007: MISO  output  1  serial data out.
- REQ-008: rx_data  output  DATA_W+2  received word {cmd[1:0], payload}.
- REQ-009: rx_valid  output  1  one-cycle strobe qualifying rx_data.
- REQ-010: tx_data  input  DATA_W  read-back data to serialise.
- REQ-011: tx_valid  input  1  qualifies tx_data; sampled only in READ_DATA after rx_valid.

Function
- REQ-012: FSM states are IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; a 1-bit flag rd_addr_done is kept across frames.
- REQ-013: IDLE goes to CHK_CMD on the first rising edge where SS_n=0.
- REQ-014: In CHK_CMD the sampled MOSI is cmd[1] and is shifted in. 0 -> WRITE; 1 and rd_addr_done=0 -> READ_ADD; 1 and rd_addr_done=1 -> READ_DATA.
- REQ-015: In WRITE/READ_ADD/READ_DATA, the remaining DATA_W+1 bits are shifted in, one per cycle; the bit counter is $clog2(DATA_W+2) wide.
- REQ-016: The cycle after the (DATA_W+2)th bit is sampled, rx_valid=1 for exactly one cycle and rx_data holds the word, with the payload de-reversed when LSB_FIRST=1. rx_data holds its value until the next rx_valid.
- REQ-017: On READ_ADD rx_valid, rd_addr_done is set to 1.
- REQ-018: In READ_DATA after rx_valid, the FSM waits indefinitely for tx_valid=1. tx_data is latched on that edge.
- REQ-019: MISO drives the latched bits from the next cycle for DATA_W cycles, in the order set by LSB_FIRST. rd_addr_done clears after the last bit.
- REQ-020: MISO=0 whenever no read-back bit is being driven.
- REQ-021: tx_valid outside the REQ-018 window is ignored.
- REQ-022: After a completed word, extra clocks with SS_n=0 are ignored; the FSM holds until SS_n=1.
- REQ-023: SS_n=1 in any state -> IDLE on the next edge. The bit counter clears and the partial word is discarded (no rx_valid). Any MISO transfer aborts; MISO=0 and rd_addr_done is retained.
- REQ-024: SS_n=1 on the same edge as the final bit: the bit is captured and rx_valid is still asserted.

Reset
- REQ-025: rst_n=0 asynchronously forces IDLE, rd_addr_done=0, counter=0, shift registers=0, MISO=0, rx_valid=0, rx_data=0, and frame_err=0 when present.
- REQ-026: Reset mid-transfer discards all frame state; operation restarts only at a new SS_n falling edge after rst_n=1.

Configuration
- REQ-027: Macro SPI_SLAVE_FRAME_ERR_EN defined: adds output port frame_err (1 bit). It pulses for one cycle when SS_n=1 is sampled with bit count 1..DATA_W+1, or during a MISO read-back.
- REQ-028: Macro SPI_SLAVE_FRAME_ERR_EN undefined: port frame_err and its logic are absent; all other behaviour is identical.

Verification (DATA_W=8)
- REQ-029: Write: SS_n low, MOSI 0,0 then 0xA5 MSB first -> a single rx_valid pulse the cycle after the 10th bit, rx_data=10'h0A5, MISO=0 throughout.
- REQ-030: Read sequence from reset: frame 1,0 + 0x3C -> rx_data=10'h23C and rd_addr_done=1. Frame 1,1 + 0x00 -> rx_data=10'h300; then tx_valid with tx_data=0x96 -> MISO 1,0,0,1,0,1,1,0 on the next 8 cycles, then rd_addr_done=0.
- REQ-031: Abort: SS_n high after 5 bits -> no rx_valid, IDLE next cycle, frame_err pulse when enabled. A following full write frame is received correctly.
- REQ-032: rst_n low during the 4th MISO bit -> MISO=0 immediately, all outputs at reset values, rd_addr_done=0.
- REQ-033: LSB_FIRST=1: MOSI 0,0 then payload bits 1,0,1,0,0,1,0,1 -> rx_data=10'h0A5. Read-back of 0x96 -> MISO 0,1,1,0,1,0,0,1.
- REQ-034: First read frame after reset with cmd 1,1 -> takes the READ_ADD path, sets rd_addr_done, and drives no MISO transfer.
